// File: rtl/traffic_light_monitor.sv
// Checks lamp codes from a two-road light controller for conflicts, invalid codes,
// illegal phase order and short yellow/all-red dwells; counts completed cross-road services.
module traffic_light_monitor #(
    parameter int unsigned YEL_MIN    = 3,
    parameter int unsigned ALLRED_MIN = 2,
    parameter int unsigned CNT_W      = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       highway,
    input  logic [1:0]       cross_road,
    input  logic             clr_fault,
    output logic             fault,
    output logic [2:0]       fault_code,
    output logic [2:0]       phase,
    output logic [CNT_W-1:0] service_count
);

    typedef enum logic [2:0] {
        S0   = 3'b000,
        S1   = 3'b001,
        S2   = 3'b010,
        S3   = 3'b011,
        S4   = 3'b100,
        SYNC = 3'b111
    } phase_t;

    localparam logic [CNT_W-1:0] YEL_MIN_C    = CNT_W'(YEL_MIN);
    localparam logic [CNT_W-1:0] ALLRED_MIN_C = CNT_W'(ALLRED_MIN);
    localparam logic [CNT_W-1:0] DWELL_ONE    = CNT_W'(1);

    logic [1:0]       cap_hw, cap_cr, prev_hw, prev_cr;
    logic             cap_vld;
    logic [CNT_W-1:0] dwell;
    logic             dwell_ok, dwell_ok_nx;
    phase_t           state, state_nx, cap_phase;
    logic             conflict, invalid;
    logic             det, svc_inc;
    logic [2:0]       det_code;

    function automatic phase_t succ(input phase_t p);
        case (p)
            S0:      succ = S1;
            S1:      succ = S2;
            S2:      succ = S3;
            S3:      succ = S4;
            S4:      succ = S0;
            default: succ = SYNC;
        endcase
    endfunction

    always_comb begin
        case ({cap_hw, cap_cr})
            4'b1000: cap_phase = S0;
            4'b0100: cap_phase = S1;
            4'b0000: cap_phase = S2;
            4'b0010: cap_phase = S3;
            4'b0001: cap_phase = S4;
            default: cap_phase = SYNC;
        endcase
    end

    assign conflict = (cap_hw != 2'b00) && (cap_cr != 2'b00);
    assign invalid  = (cap_hw == 2'b11) || (cap_cr == 2'b11);

    // Every lamp code is either one of the five legal phases, a conflict or invalid,
    // so cap_phase is a real phase in every branch below that loads it.
    always_comb begin
        state_nx    = state;
        dwell_ok_nx = dwell_ok;
        det         = 1'b0;
        det_code    = 3'b000;
        svc_inc     = 1'b0;
        if (cap_vld) begin
            if (conflict) begin
                det         = 1'b1;
                det_code    = 3'b001;
                state_nx    = SYNC;
                dwell_ok_nx = 1'b0;
            end else if (invalid) begin
                det         = 1'b1;
                det_code    = 3'b010;
                state_nx    = SYNC;
                dwell_ok_nx = 1'b0;
            end else if (state == SYNC) begin
                state_nx    = cap_phase;
                dwell_ok_nx = 1'b0;
            end else if (cap_phase != state) begin
                if (cap_phase == succ(state)) begin
                    state_nx    = cap_phase;
                    dwell_ok_nx = 1'b1;
                    svc_inc     = (state == S4);
                    if (dwell_ok && (state == S1 || state == S4) && dwell < YEL_MIN_C) begin
                        det      = 1'b1;
                        det_code = 3'b100;
                    end else if (dwell_ok && state == S2 && dwell < ALLRED_MIN_C) begin
                        det      = 1'b1;
                        det_code = 3'b101;
                    end
                end else begin
                    det         = 1'b1;
                    det_code    = 3'b011;
                    state_nx    = cap_phase;
                    dwell_ok_nx = 1'b0;
                end
            end
        end
    end

    // cap_vld keeps the reset-value red/red capture from being treated as a real sample.
    always_ff @(posedge clk) begin
        if (rst) begin
            cap_hw        <= 2'b00;
            cap_cr        <= 2'b00;
            prev_hw       <= 2'b00;
            prev_cr       <= 2'b00;
            cap_vld       <= 1'b0;
            dwell         <= '0;
            dwell_ok      <= 1'b0;
            state         <= SYNC;
            fault         <= 1'b0;
            fault_code    <= 3'b000;
            service_count <= '0;
        end else begin
            cap_hw   <= highway;
            cap_cr   <= cross_road;
            prev_hw  <= cap_hw;
            prev_cr  <= cap_cr;
            cap_vld  <= 1'b1;
            state    <= state_nx;
            dwell_ok <= dwell_ok_nx;
            if (cap_vld) begin
                if ({cap_hw, cap_cr} != {prev_hw, prev_cr})
                    dwell <= DWELL_ONE;
                else if (dwell != '1)
                    dwell <= dwell + 1'b1;
            end
            if (det) begin
                fault <= 1'b1;
                if (!fault || clr_fault)
                    fault_code <= det_code;
            end else if (clr_fault) begin
                fault      <= 1'b0;
                fault_code <= 3'b000;
            end
            if (svc_inc)
                service_count <= service_count + 1'b1;
        end
    end

    assign phase = state;

endmodule

// File: tb/tb_traffic_light_monitor.sv
// Directed vector table plus hand-written wrap and reset sequences for traffic_light_monitor.
module tb_traffic_light_monitor;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] highway, cross_road;
    logic       clr_fault;
    logic       fault;
    logic [2:0] fault_code;
    logic [2:0] phase;
    logic [7:0] service_count;

    int unsigned total = 0;
    int unsigned bad   = 0;

    traffic_light_monitor #(.YEL_MIN(3), .ALLRED_MIN(2), .CNT_W(8)) dut (
        .clk           (clk),
        .rst           (rst),
        .highway       (highway),
        .cross_road    (cross_road),
        .clr_fault     (clr_fault),
        .fault         (fault),
        .fault_code    (fault_code),
        .phase         (phase),
        .service_count (service_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  hw;
        logic [1:0]  cr;
        logic        clr;
        int unsigned n;
        logic        f;
        logic [2:0]  code;
        logic [2:0]  ph;
        logic [7:0]  svc;
    } vec_t;

    vec_t tbl [21];

    task automatic tick(input int unsigned n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic check_all(input string tag, input logic f, input logic [2:0] code,
                             input logic [2:0] ph, input logic [7:0] svc);
        check({tag, ".fault"}, 32'(fault), 32'(f));
        check({tag, ".code"}, 32'(fault_code), 32'(code));
        check({tag, ".phase"}, 32'(phase), 32'(ph));
        check({tag, ".svc"}, 32'(service_count), 32'(svc));
    endtask

    task automatic seg(input logic [1:0] hw, input logic [1:0] cr, input int unsigned n);
        highway    = hw;
        cross_road = cr;
        tick(n);
    endtask

    task automatic one_cycle();
        seg(2'b01, 2'b00, 3);
        seg(2'b00, 2'b00, 2);
        seg(2'b00, 2'b10, 1);
        seg(2'b00, 2'b01, 3);
        seg(2'b10, 2'b00, 1);
    endtask

    initial begin
        //        hw     cr     clr  n  f     code    ph      svc
        tbl[0]  = '{2'b10, 2'b00, 0, 5, 0, 3'd0, 3'd0, 8'd0};
        tbl[1]  = '{2'b01, 2'b00, 0, 3, 0, 3'd0, 3'd1, 8'd0};
        tbl[2]  = '{2'b00, 2'b00, 0, 2, 0, 3'd0, 3'd2, 8'd0};
        tbl[3]  = '{2'b00, 2'b10, 0, 4, 0, 3'd0, 3'd3, 8'd0};
        tbl[4]  = '{2'b00, 2'b01, 0, 3, 0, 3'd0, 3'd4, 8'd0};
        tbl[5]  = '{2'b10, 2'b00, 0, 2, 0, 3'd0, 3'd0, 8'd1};
        tbl[6]  = '{2'b01, 2'b00, 0, 2, 0, 3'd0, 3'd1, 8'd1};
        tbl[7]  = '{2'b00, 2'b00, 0, 2, 1, 3'd4, 3'd2, 8'd1};
        tbl[8]  = '{2'b10, 2'b01, 1, 2, 1, 3'd1, 3'd7, 8'd1};
        tbl[9]  = '{2'b10, 2'b00, 0, 2, 1, 3'd1, 3'd0, 8'd1};
        tbl[10] = '{2'b10, 2'b00, 1, 2, 0, 3'd0, 3'd0, 8'd1};
        tbl[11] = '{2'b00, 2'b00, 0, 2, 1, 3'd3, 3'd2, 8'd1};
        tbl[12] = '{2'b00, 2'b00, 1, 2, 0, 3'd0, 3'd2, 8'd1};
        tbl[13] = '{2'b00, 2'b10, 0, 3, 0, 3'd0, 3'd3, 8'd1};
        tbl[14] = '{2'b11, 2'b10, 0, 2, 1, 3'd1, 3'd7, 8'd1};
        tbl[15] = '{2'b00, 2'b00, 1, 2, 0, 3'd0, 3'd2, 8'd1};
        tbl[16] = '{2'b11, 2'b00, 0, 2, 1, 3'd2, 3'd7, 8'd1};
        tbl[17] = '{2'b10, 2'b00, 1, 2, 0, 3'd0, 3'd0, 8'd1};
        tbl[18] = '{2'b01, 2'b00, 0, 3, 0, 3'd0, 3'd1, 8'd1};
        tbl[19] = '{2'b00, 2'b00, 0, 1, 0, 3'd0, 3'd1, 8'd1};
        tbl[20] = '{2'b00, 2'b10, 0, 2, 1, 3'd5, 3'd3, 8'd1};

        rst        = 1'b1;
        highway    = 2'b00;
        cross_road = 2'b00;
        clr_fault  = 1'b0;
        tick(2);
        check_all("reset0", 1'b0, 3'd0, 3'd7, 8'd0);
        rst = 1'b0;

        for (int i = 0; i < 21; i++) begin
            highway    = tbl[i].hw;
            cross_road = tbl[i].cr;
            clr_fault  = tbl[i].clr;
            tick(tbl[i].n);
            check_all($sformatf("row%0d", i), tbl[i].f, tbl[i].code, tbl[i].ph, tbl[i].svc);
        end
        clr_fault = 1'b0;

        // reset while faulted clears everything
        rst = 1'b1;
        seg(2'b10, 2'b00, 2);
        check_all("reset1", 1'b0, 3'd0, 3'd7, 8'd0);
        rst = 1'b0;
        seg(2'b10, 2'b00, 2);
        check_all("wrap_start", 1'b0, 3'd0, 3'd0, 8'd0);

        for (int c = 0; c < 255; c++) one_cycle();
        tick(1);
        check_all("wrap_255", 1'b0, 3'd0, 3'd0, 8'd255);
        one_cycle();
        tick(1);
        check_all("wrap_0", 1'b0, 3'd0, 3'd0, 8'd0);
        one_cycle();
        tick(1);
        check_all("wrap_1", 1'b0, 3'd0, 3'd0, 8'd1);

        seg(2'b01, 2'b00, 3);
        seg(2'b00, 2'b00, 2);
        seg(2'b00, 2'b10, 3);
        check_all("mid_s3", 1'b0, 3'd0, 3'd3, 8'd1);
        rst = 1'b1;
        tick(1);
        check_all("rst_mid_s3", 1'b0, 3'd0, 3'd7, 8'd0);
        rst = 1'b0;
        tick(1);
        check_all("post_rst1", 1'b0, 3'd0, 3'd7, 8'd0);
        tick(1);
        check_all("post_rst2", 1'b0, 3'd0, 3'd3, 8'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/traffic_light_monitor.md
TRAFFIC_LIGHT_MONITOR -- requirements
Module: traffic_light_monitor

Interface
REQ-001 Parameter YEL_MIN, default 3: minimum legal yellow dwell, in clock cycles.
REQ-002 Parameter ALLRED_MIN, default 2: minimum legal all-red dwell before cross_road green, in cycles.
REQ-003 Parameter CNT_W, default 8: width of the dwell counter and of service_count.
REQ-004 clk  input  1  rising-edge clock; the only clock.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 highway  input  2  lamp code driven by the light controller: red=00, yellow=01, green=10; 11 is invalid.
REQ-007 cross_road  input  2  lamp code, same encoding as highway.
REQ-008 clr_fault  input  1  synchronous clear of fault and fault_code.
REQ-009 fault  output  1  sticky fault flag.
REQ-010 fault_code  output  3  code of the first fault since the last clear.
REQ-011 phase  output  3  tracked phase: S0=000, S1=001, S2=010, S3=011, S4=100, SYNC=111.
REQ-012 service_count  output  CNT_W  count of completed cross-road service cycles.

Function
REQ-013 Input capture: both lamp inputs are registered on every rising edge. All checks use the captured value compared against the previous captured value. Results (fault, fault_code, phase, service_count) update on the next edge, giving 2-edge latency from input change to output.
REQ-014 Legal combinations (highway/cross_road):
- S0 = green/red
- S1 = yellow/red
- S2 = red/red
- S3 = red/green
- S4 = red/yellow
REQ-015 Legal phase sequence: S0->S1->S2->S3->S4->S0. Remaining in the same phase is always legal.
REQ-016 Fault codes and checks:
- 001 conflict: both codes non-red.
- 010 invalid: either code is 11.
- 011 sequence: a change to any combination other than the expected next phase.
- 100 short yellow: leaving S1 or S4 with dwell < YEL_MIN.
- 101 short all-red: leaving S2 with dwell < ALLRED_MIN.
REQ-017 Priority: if several checks fire on the same sample, the lowest code is reported.
REQ-018 fault_code latching: fault_code is loaded only when fault is 0. Later faults set nothing new; the first cause is kept.
REQ-019 Dwell counter: resets to 1 on any change of the captured combination, otherwise increments, and saturates at 2^CNT_W-1.
REQ-020 Dwell validity: dwell checks apply only if the phase being left was entered by a legal transition, not directly from SYNC or a resync.
REQ-021 Phase on a legal change: phase advances to the new combination.
REQ-022 Phase on a sequence fault: phase loads the observed legal combination (resync).
REQ-023 Phase on conflict or invalid: phase goes to SYNC.
REQ-024 Leaving SYNC: the first captured legal combination is loaded into phase without a sequence check. Conflict and invalid checks remain active while in SYNC.
REQ-025 service_count increments, wrapping, on each legal S4->S0 transition. It is not incremented on a resync into S0.
REQ-026 clr_fault: on clr_fault=1, fault and fault_code are cleared to 0. If a new fault is detected on the same edge, the new fault wins: fault=1 and fault_code is set to the new code.
REQ-027 clr_fault does not affect phase, the dwell counter or service_count.

Reset
REQ-028 On rst=1 at a rising edge, all of the following are set: fault=0, fault_code=000, phase=SYNC, service_count=0, dwell=0, captured inputs=red/red, dwell-valid flag cleared.
REQ-029 rst has priority over clr_fault and over all checks.
REQ-030 rst asserted mid-sequence discards all history; no fault is raised on the first sample after reset.

Verification
REQ-031 Normal cycle: reset, then S0(5), S1(3), S2(2), S3(4), S4(3), S0, with durations in cycles -> fault stays 0, phase follows the sequence with 2-edge lag, service_count=1.
REQ-032 Short yellow: legal entry into S1, 2 cycles, then S2 -> fault=1, fault_code=100, phase=S2.
REQ-033 Conflict: inject green/yellow -> fault=1, fault_code=001, phase=SYNC. Then S0 -> phase=S0 and fault stays 1.
REQ-034 Sequence plus clear: go S0->S2 directly -> fault_code=011, phase=S2. Then pulse clr_fault -> fault=0, fault_code=000. Then a legal S3 produces no new fault.
REQ-035 Simultaneous conflict and invalid: inject 11/10 -> fault_code=001.
REQ-036 Wrap: run 2^CNT_W complete cycles -> service_count returns to 0. Assert rst mid-S3 -> phase=SYNC, service_count=0.
